// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion sequencer with an 11-entry round-key buffer and registered read port.
// Optional feature macro: KEYSCHED_REVERSE_RD_EN mirrors the read index (rd_sel 0 returns round key 10).
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_sel,
  output logic [127:0] rd_key
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  logic [127:0] rd_key_q, rd_key_d;
  logic [127:0] prev_key;
  logic [31:0] t, n0, n1, n2, n3;
  logic [3:0] rd_idx;
  logic accept;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    accept  = key_valid && key_ready;
    state_d = (state_q == EXPAND) ? ((rnd_q == 4'd10) ? DONE : EXPAND)
                                  : (accept ? EXPAND : state_q);
  end
  always_comb begin
    key_ready  = state_q != EXPAND;
    busy       = state_q == EXPAND;
    keys_valid = state_q == DONE;
    sub_in     = busy ? {prev_key[23:0], prev_key[31:24]} : 32'h0;
    rd_key     = rd_key_q;
  end
  // Each round key derives from the previous one; the S-box returns within the same cycle.
  always_comb begin
    prev_key = (rnd_q != 4'd0 && rnd_q <= 4'd10) ? rk_q[rnd_q - 4'd1] : 128'h0;
    t  = sub_out ^ {rcon(rnd_q), 24'h0};
    n0 = prev_key[127:96] ^ t;
    n1 = prev_key[95:64] ^ n0;
    n2 = prev_key[63:32] ^ n1;
    n3 = prev_key[31:0] ^ n2;
  end
  always_comb begin
    rnd_d = rnd_q;
    rk_d  = rk_q;
    if (state_q == EXPAND) begin
      rk_d[rnd_q] = {n0, n1, n2, n3};
      rnd_d = (rnd_q == 4'd10) ? 4'd0 : rnd_q + 4'd1;
    end else if (accept) begin
      rk_d[0] = key_in;
      rnd_d = 4'd1;
    end
  end
  always_comb begin
`ifdef KEYSCHED_REVERSE_RD_EN
    rd_idx = 4'd10 - rd_sel;
`else
    rd_idx = rd_sel;
`endif
    rd_key_d = (rd_sel <= 4'd10) ? rk_q[rd_idx] : 128'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q    <= 4'd0;
      rk_q     <= '{default: 128'h0};
      rd_key_q <= 128'h0;
    end else begin
      rnd_q    <= rnd_d;
      rk_q     <= rk_d;
      rd_key_q <= rd_key_d;
    end
  end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed FIPS-197 vectors and handshake/reset sequences for aes_key_sched_ctrl.
module tb_aes_key_sched_ctrl;
  logic clk = 1'b0;
  logic rst, key_valid, key_ready, busy, keys_valid;
  logic [127:0] key_in, rd_key;
  logic [31:0] sub_in, sub_out;
  logic [3:0] rd_sel;
  int checks = 0;
  int errors = 0;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  typedef struct {
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [16];
  logic [127:0] fips_rk [0:10];
  int lows, rlows;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction
  function automatic logic [3:0] phys(input int i);
`ifdef KEYSCHED_REVERSE_RD_EN
    return 4'(10 - i);
`else
    return 4'(i);
`endif
  endfunction
  assign sub_out = {sb(sub_in[31:24]), sb(sub_in[23:16]), sb(sub_in[15:8]), sb(sub_in[7:0])};
  always #5 clk = ~clk;
  aes_key_sched_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .sub_in(sub_in), .sub_out(sub_out), .busy(busy), .keys_valid(keys_valid),
    .rd_sel(rd_sel), .rd_key(rd_key)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [3:0] s, output logic [127:0] k);
    rd_sel = s;
    @(negedge clk);
    k = rd_key;
  endtask
  // Counts samples before keys_valid rises, and how many of those had key_ready low with busy high.
  task automatic wait_done(output int lo, output int rl);
    lo = 0;
    rl = 0;
    for (int c = 0; c < 20 && !keys_valid; c++) begin
      if (!key_ready && busy) rl++;
      lo++;
      @(negedge clk);
    end
    chk("keys_valid_timeout", 128'(keys_valid), 128'd1);
  endtask
  initial begin
    logic [127:0] k;
    fips_rk[0]  = K1;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 16; i++) tbl[i] = (i <= 10) ? '{phys(i), fips_rk[i]} : '{4'(i), 128'h0};
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_sub_in", 128'(sub_in), 128'd0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), k);
      chk($sformatf("rst_rd_%0d", i), k, 128'h0);
    end
    key_in = K1; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("fips_busy", 128'(busy), 128'd1);
    chk("fips_sub_in_r1", 128'(sub_in), 128'hcf4f3c09);
    wait_done(lows, rlows);
    chk("fips_latency", 128'(lows), 128'd10);
    chk("fips_ready_low", 128'(rlows), 128'd10);
    chk("fips_done_ready", 128'(key_ready), 128'd1);
    chk("fips_done_sub_in", 128'(sub_in), 128'd0);
    for (int i = 0; i < 16; i++) begin
      rd(tbl[i].sel, k);
      chk($sformatf("fips_rd_sel_%0d", tbl[i].sel), k, tbl[i].exp);
    end
    chk("fips_hold_valid", 128'(keys_valid), 128'd1);
    rd_sel = phys(0); key_in = K1; key_valid = 1'b1;
    @(negedge clk);
    key_in = K2;
    wait_done(lows, rlows);
    chk("hs_latency", 128'(lows), 128'd10);
    chk("hs_ready_low", 128'(rlows), 128'd10);
    chk("hs_no_mid_accept", rd_key, K1);
    @(negedge clk);
    key_valid = 1'b0;
    chk("hs_reaccept_kv", 128'(keys_valid), 128'd0);
    chk("hs_reaccept_busy", 128'(busy), 128'd1);
    wait_done(lows, rlows);
    chk("hs2_latency", 128'(lows), 128'd10);
    rd(phys(0), k);
    chk("hs2_rk0", k, K2);
    rd(phys(1), k);
    chk("hs2_rk1", k, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rd(phys(10), k);
    chk("hs2_rk10", k, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    key_in = K1; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 128'(key_ready), 128'd1);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_kv", 128'(keys_valid), 128'd0);
    chk("mid_rst_sub_in", 128'(sub_in), 128'd0);
    for (int i = 0; i <= 10; i++) begin
      rd(phys(i), k);
      chk($sformatf("mid_rst_rk_%0d", i), k, 128'h0);
    end
    repeat (12) @(negedge clk);
    chk("mid_rst_stays_idle", {126'h0, keys_valid, busy}, 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for AES-128 key expansion. Accepts a 128-bit cipher key over a valid/ready handshake and steps the round counter 1..10, one round key per cycle. It applies the round constant from its internal rcon table and uses an external 4-byte S-box for SubWord. The 11 round keys are held in a local buffer that the cipher round engine reads through a registered port.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  cipher key offered
- key_ready  out  1  block can accept a key
- key_in  in  128  cipher key; key_in[127:96] = w0
- sub_in  out  32  RotWord(w3) of the previous round key, sent to the external S-box
- sub_out  in  32  SubWord(sub_in), combinational return from the external S-box
- busy  out  1  expansion in progress
- keys_valid  out  1  all 11 round keys stored and readable
- rd_sel  in  4  round-key index 0..10
- rd_key  out  128  round key selected by rd_sel on the previous cycle

## Operation
- States: IDLE, EXPAND, DONE. Round counter rnd is 4 bits.
- Reset values: state=IDLE, rnd=0, key_ready=1, busy=0, keys_valid=0, rd_key=0, all buffer entries=0.
- Handshake: a key is accepted on an edge where key_valid && key_ready. key_ready = (state != EXPAND).
- IDLE or DONE + accept:
  - rk[0] <= key_in; rnd <= 1; state <= EXPAND.
  - keys_valid drops the cycle after the accept.
  - Accepting in DONE overwrites the old schedule.
- EXPAND, each cycle:
  - Let p = rk[rnd-1], split as words w0..w3 with w0 = p[127:96].
  - sub_in = {w3[23:0], w3[31:24]}.
  - t = sub_out ^ {rcon(rnd), 24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - rk[rnd] <= {n0,n1,n2,n3}; rnd <= rnd+1.
  - When rnd==10: state <= DONE and rnd <= 0.
- rcon table: rnd 1..10 maps to 01,02,04,08,10,20,40,80,1b,36. All other rnd values give 00.
- sub_in is 0 outside EXPAND.
- busy = (state==EXPAND); keys_valid = (state==DONE).
- Read port:
  - rd_key <= rk[rd_sel] every cycle, in any state.
  - rd_sel 11..15 gives 0.
  - Reads during EXPAND return the current buffer contents, which may be stale or partial.
- All arithmetic is XOR only, with no width growth. rnd never exceeds 10.

## Timing
- Key accepted on edge N: rk[0] is written at N, rk[r] at N+r, and state=DONE after edge N+10.
- keys_valid is high from cycle N+10 onward, i.e. 10 cycles after the accept edge.
- key_ready is low for exactly cycles N+1..N+10 (10 cycles), then high again in DONE.
- The external S-box path is combinational within a single cycle: sub_in → sub_out → rk write.
- Read latency is 1 cycle: rd_sel sampled at edge M gives rd_key valid after M.
- rst asserted mid-EXPAND:
  - Next edge returns to IDLE and clears rnd, the flags and the buffer.
  - No partial schedule is flagged valid.
- key_valid held high in DONE causes back-to-back re-expansion. Each accept restarts from rk[0].

## Configuration
- KEYSCHED_REVERSE_RD_EN
  - Defined: the read index is mirrored, so rd_key <= rk[10-rd_sel] for rd_sel 0..10. This serves the decryption round order (rd_sel 0 returns round key 10). rd_sel 11..15 still gives 0.
  - Undefined: direct indexing as in Operation.
  - Expansion, handshake and timing are identical in both builds.

## Test plan
- Reset: hold rst for 2 cycles, then check key_ready=1, busy=0, keys_valid=0, sub_in=0 and rd_key=0 for every rd_sel.
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, with the bench modelling the S-box.
  - keys_valid rises 10 cycles after the accept.
  - rd_sel=1 → a0fafe1788542cb123a339392a6c7605.
  - rd_sel=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_sel=0 → the key itself.
- Handshake: keep key_valid high through EXPAND with a second key. Check key_ready=0 for 10 cycles, no accept mid-expansion, then the second key is accepted in DONE and keys_valid drops for 10 cycles.
- Reset mid-op: assert rst at round 5, then check state IDLE, keys_valid=0, and rk[1..10] read back as 0.
- Out-of-range read: rd_sel=11 and rd_sel=15 after DONE → rd_key=0.
- KEYSCHED_REVERSE_RD_EN build, same vector: rd_sel=0 → d014f9a8c9ee2589e13f0cc8b6630ca6 and rd_sel=10 → 2b7e151628aed2a6abf7158809cf4f3c.
